// File: rtl/mult_seq.sv
// mult_seq: sequential 32x32 signed radix-2 Booth multiplier.
// Every add or subtract step uses an external shared 32-bit adder
// (add_a/add_b/add_cin out, add_sum back in the same cycle).
// Optional feature: define MULT_SEQ_OVF_DETECT_EN to flag products that
// do not fit in 32 signed bits; otherwise data_exception is tied low.
module mult_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        data_exception,
  output logic        busy
);

  localparam int unsigned W       = 32;
  localparam int unsigned CW      = 5;
  localparam int unsigned LAST_IT = W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  m_q,   m_d;
  logic [W-1:0]  hi_q,  hi_d;
  logic [W-1:0]  lo_q,  lo_d;
  logic          qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;

  logic          start;
  logic          last_iter;
  logic          add_ovf;
  logic          sum_sign;
  logic [W-1:0]  hi_nx;
  logic [W-1:0]  lo_nx;

  // A start is accepted from IDLE or DONE; requests during RUN are ignored
  assign start     = ctrl_MULT && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (state_q == S_RUN) && (cnt_q == CW'(LAST_IT));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_MULT) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = ctrl_MULT ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: status flags and Booth operand selection for the shared adder
  always_comb begin
    add_a          = '0;
    add_b          = '0;
    add_cin        = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_q)
      S_RUN: begin
        busy  = 1'b1;
        add_a = hi_q;
        case ({lo_q[0], qm1_q})
          2'b01: add_b = m_q;
          2'b10: begin
            add_b   = ~m_q;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      S_DONE:  data_resultRDY = 1'b1;
      default: ;
    endcase
  end

  // Shifted partial product; the 33rd sum bit is recovered from signed overflow
  always_comb begin
    add_ovf  = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    sum_sign = add_sum[W-1] ^ add_ovf;
    hi_nx    = {sum_sign, add_sum[W-1:1]};
    lo_nx    = {add_sum[0], lo_q[W-1:1]};
  end

  // Datapath next-state: load on start, one Booth step per RUN cycle
  always_comb begin
    m_d   = m_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (start) begin
      m_d   = data_operandA;
      hi_d  = '0;
      lo_d  = data_operandB;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      hi_d  = hi_nx;
      lo_d  = lo_nx;
      qm1_d = lo_q[0];
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        res_d = lo_nx;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      m_q   <= m_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign data_result = res_q;

`ifdef MULT_SEQ_OVF_DETECT_EN
  logic exc_q, exc_d;

  // Overflow when the high word is not a pure sign extension of the low word
  always_comb begin
    exc_d = exc_q;
    if (last_iter) begin
      exc_d = (hi_nx != {W{lo_nx[W-1]}});
    end
  end

  // Exception flag register, updated together with the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ctrl_MULT  in  1  start request, sampled on rising edge.
REQ-004 SHALL have port: data_operandA  in  32  multiplicand M, two's complement.
REQ-005 SHALL have port: data_operandB  in  32  multiplier Q, two's complement.
REQ-006 SHALL have port: add_a  out  32  operand A to the shared 32-bit CLA adder.
REQ-007 SHALL have port: add_b  out  32  operand B to the shared adder.
REQ-008 SHALL have port: add_cin  out  1  carry-in to the shared adder.
REQ-009 SHALL have port: add_sum  in  32  combinational sum returned by the shared adder in the same cycle.
REQ-010 SHALL have port: data_result  out  32  low 32 bits of M*Q.
REQ-011 SHALL have port: data_resultRDY  out  1  one-cycle result-valid pulse.
REQ-012 SHALL have port: data_exception  out  1  product overflow flag.
REQ-013 SHALL have port: busy  out  1  high while a multiply is in progress.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE->RUN on ctrl_MULT=1.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally, or DONE->RUN if ctrl_MULT=1.
REQ-015 SHALL, on start at edge E0: latch M, set P = {32'h0, Q, 1'b0} (65 bits: hi, lo, q-1), set count=0.
REQ-016 SHALL perform radix-2 Booth in RUN, one iteration per edge E1..E32, selected by {lo[0], q-1}:
- 01: add_b=M, cin=0.
- 10: add_b=~M, cin=1.
- 00/11: add_b=0, cin=0.
- add_a=hi in all cases.
REQ-017 SHALL, each iteration, arithmetic-shift-right {add_sum, lo, q-1} by one, shifting in the true sign of the 33-bit sum (add_sum[31] XOR signed overflow of the add).
REQ-018 SHALL route every iteration through the shared adder; no local adder or subtractor is permitted.
REQ-019 SHALL drive add_a=0, add_b=0, add_cin=0 in IDLE and DONE.
REQ-020 SHALL hold data_resultRDY=1 for exactly the cycle between E32 and E33 (latency 33 edges from start sample).
REQ-021 SHALL make data_result = lo from E32 and hold it stable until the next start's completion.
REQ-022 SHALL hold busy=1 from E0 through E32, and busy=0 otherwise.
REQ-023 SHALL ignore ctrl_MULT while in RUN; operands and progress are unaffected.
REQ-024 SHALL, on ctrl_MULT in DONE, accept back-to-back: new operands are latched and the RDY pulse still occurs for the previous result.
REQ-025 SHALL perform 32x32 signed arithmetic, with only the low 32 product bits exposed.

Reset
REQ-026 SHALL, on reset_n=0 at any time including mid-RUN: enter IDLE asynchronously, clear P, M and count, and force all outputs to 0.
REQ-027 SHALL NOT produce an RDY pulse for an operation aborted by reset.

Configuration
REQ-028 SHALL, with macro MULT_SEQ_OVF_DETECT_EN defined: set data_exception at E32 when hi != {32{lo[31]}}, and hold it with data_result.
REQ-029 SHALL, without MULT_SEQ_OVF_DETECT_EN: tie data_exception to 0 and omit the comparator logic.

Verification
REQ-030 SHALL verify: A=3, B=4, ctrl_MULT pulse -> RDY high 33 edges later, result=12, exception=0.
REQ-031 SHALL verify: A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6, exception=0.
REQ-032 SHALL verify: A=0x80000000, B=0xFFFFFFFF -> result=0x80000000; exception=1 with MULT_SEQ_OVF_DETECT_EN, 0 without.
REQ-033 SHALL verify: A=0x00010000, B=0x00010000 -> result=0, exception=1 (macro defined).
REQ-034 SHALL verify: second ctrl_MULT at E10 with different operands -> ignored; first result delivered at E33 unchanged.
REQ-035 SHALL verify: reset_n low at E15 -> busy, RDY and add_* all 0 immediately; no RDY pulse follows; a fresh start then completes normally.
